// File: rtl/zero_flag_pipe.sv
// Two-stage pipelined zero detector with architectural NZCV flag register.
// Stage 1 OR-reduces CHUNK-bit slices; stage 2 folds the chunk flags and commits NZCV.
module zero_flag_pipe #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic             in_set_flags,
  input  logic             flush,
  output logic             out_valid,
  output logic             out_zero,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flags_pending
);

  localparam int NCH = WIDTH / CHUNK;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_width
      $error("zero_flag_pipe: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  logic [NCH-1:0] w_chunk_nz;
  logic           w_s1_load;
  logic           w_s2_load;
  logic           w_flag_load;
  logic           w_s1_zero;

  logic [NCH-1:0] r_s1_nz;
  logic           r_s1_valid;
  logic           r_s1_sign;
  logic           r_s1_carry;
  logic           r_s1_overflow;
  logic           r_s1_set_flags;
  logic           r_out_valid;
  logic           r_out_zero;
  logic           r_flag_n;
  logic           r_flag_z;
  logic           r_flag_c;
  logic           r_flag_v;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chunk
      assign w_chunk_nz[gi] = |in_result[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign w_s1_load   = in_valid && !flush;
  assign w_s2_load   = r_s1_valid && !flush;
  assign w_flag_load = w_s2_load && r_s1_set_flags;
  assign w_s1_zero   = ~|r_s1_nz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid     <= 1'b0;
      r_s1_nz        <= '0;
      r_s1_sign      <= 1'b0;
      r_s1_carry     <= 1'b0;
      r_s1_overflow  <= 1'b0;
      r_s1_set_flags <= 1'b0;
    end else begin
      r_s1_valid <= w_s1_load;
      if (w_s1_load) begin
        r_s1_nz        <= w_chunk_nz;
        r_s1_sign      <= in_result[WIDTH-1];
        r_s1_carry     <= in_carry;
        r_s1_overflow  <= in_overflow;
        r_s1_set_flags <= in_set_flags;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_zero  <= 1'b0;
    end else begin
      r_out_valid <= w_s2_load;
      if (w_s2_load) begin
        r_out_zero <= w_s1_zero;
      end
    end
  end

  // NZCV commits on the same edge the entry becomes out_valid; a flush kills it first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
    end else if (w_flag_load) begin
      r_flag_n <= r_s1_sign;
      r_flag_z <= w_s1_zero;
      r_flag_c <= r_s1_carry;
      r_flag_v <= r_s1_overflow;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_zero      = r_out_zero;
  assign flag_n        = r_flag_n;
  assign flag_z        = r_flag_z;
  assign flag_c        = r_flag_c;
  assign flag_v        = r_flag_v;
  assign flags_pending = r_s1_valid && r_s1_set_flags;

endmodule

// File: tb/tb_zero_flag_pipe.sv
// Directed bench for zero_flag_pipe: default 64/8 instance plus a 32/4 instance.
module tb_zero_flag_pipe;

  logic        clk;
  logic        reset;

  logic        in_valid, in_carry, in_overflow, in_set_flags, flush;
  logic [63:0] in_result;
  logic        out_valid, out_zero, flag_n, flag_z, flag_c, flag_v, flags_pending;

  logic        s_in_valid, s_in_carry, s_in_overflow, s_in_set_flags, s_flush;
  logic [31:0] s_in_result;
  logic        s_out_valid, s_out_zero, s_flag_n, s_flag_z, s_flag_c, s_flag_v, s_flags_pending;

  int errors = 0;
  int checks = 0;

  zero_flag_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_result(in_result),
    .in_carry(in_carry), .in_overflow(in_overflow), .in_set_flags(in_set_flags),
    .flush(flush), .out_valid(out_valid), .out_zero(out_zero),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .flags_pending(flags_pending)
  );

  zero_flag_pipe #(.WIDTH(32), .CHUNK(4)) dut32 (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_result(s_in_result),
    .in_carry(s_in_carry), .in_overflow(s_in_overflow), .in_set_flags(s_in_set_flags),
    .flush(s_flush), .out_valid(s_out_valid), .out_zero(s_out_zero),
    .flag_n(s_flag_n), .flag_z(s_flag_z), .flag_c(s_flag_c), .flag_v(s_flag_v),
    .flags_pending(s_flags_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [3:0] nzcv   = {flag_n, flag_z, flag_c, flag_v};
  wire [3:0] s_nzcv = {s_flag_n, s_flag_z, s_flag_c, s_flag_v};

  typedef struct {
    logic [63:0] result;
    logic        carry;
    logic        ovf;
    logic        set;
    logic        exp_zero;
    logic [3:0]  exp_nzcv;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] r, input logic c, input logic o,
                       input logic s, input logic f);
    in_valid = v; in_result = r; in_carry = c; in_overflow = o; in_set_flags = s; flush = f;
  endtask

  initial begin
    // {result, carry, ovf, set, exp_zero, exp_nzcv}
    vecs[0] = '{64'h0,                   1'b0, 1'b0, 1'b1, 1'b1, 4'b0100};
    vecs[1] = '{64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1011};
    vecs[2] = '{64'h0,                   1'b0, 1'b0, 1'b0, 1'b1, 4'b1011};
    vecs[3] = '{64'h0000_0000_0000_0100, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010};
    vecs[4] = '{64'h00FF_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010};
    vecs[5] = '{64'h0080_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};

    s_in_valid = 1'b0; s_in_result = '0; s_in_carry = 1'b0; s_in_overflow = 1'b0;
    s_in_set_flags = 1'b0; s_flush = 1'b0;

    // Reset held with a live flag-setting zero input.
    reset = 1'b1;
    drive(1'b1, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("reset_out_valid[%0d]", i), out_valid, 1'b0);
      chk($sformatf("reset_nzcv[%0d]", i), nzcv, 4'b0000);
      chk($sformatf("reset_pending[%0d]", i), flags_pending, 1'b0);
    end
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();

    // Table vectors, one at a time: pending after 1 edge, result after 2.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].result, vecs[i].carry, vecs[i].ovf, vecs[i].set, 1'b0);
      tick();
      drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_pending", i), flags_pending, vecs[i].set);
      chk($sformatf("vec%0d_early_valid", i), out_valid, 1'b0);
      tick();
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_out_zero", i), out_zero, vecs[i].exp_zero);
      chk($sformatf("vec%0d_nzcv", i), nzcv, vecs[i].exp_nzcv);
      $display("vec %0d result=%h zero=%b nzcv=%b", i, vecs[i].result, out_zero, nzcv);
    end

    // One-hot sweep, back-to-back, non-flag-setting: NZCV must stay 0000.
    for (int i = 0; i <= 64; i++) begin
      if (i < 64) drive(1'b1, 64'h1 << i, 1'b1, 1'b1, 1'b0, 1'b0);
      else        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      if (i >= 1) begin
        chk($sformatf("sweep%0d_valid", i - 1), out_valid, 1'b1);
        chk($sformatf("sweep%0d_zero", i - 1), out_zero, 1'b0);
        chk($sformatf("sweep%0d_nzcv", i - 1), nzcv, 4'b0000);
      end
    end
    tick();
    chk("sweep_drain_valid", out_valid, 1'b0);
    $display("sweep done nzcv=%b", nzcv);

    // Flush kills the stage-1 entry.
    drive(1'b1, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("flush1_pending", flags_pending, 1'b1);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("flush1_out_valid", out_valid, 1'b0);
    chk("flush1_z", flag_z, 1'b0);
    chk("flush1_pending_after", flags_pending, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("flush1_late_valid", out_valid, 1'b0);
    $display("flush stage1 valid=%b z=%b", out_valid, flag_z);

    // Flush with same-cycle input captures nothing.
    drive(1'b1, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("flush2_pending", flags_pending, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("flush2_out_valid", out_valid, 1'b0);
    chk("flush2_z", flag_z, 1'b0);
    $display("flush same-cycle valid=%b z=%b", out_valid, flag_z);

    // Flush while A sits in stage 2 and B in stage 1: A survives, B is dropped.
    drive(1'b1, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 64'h5, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("flush3_a_valid", out_valid, 1'b1);
    chk("flush3_a_nzcv", nzcv, 4'b0100);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("flush3_b_valid", out_valid, 1'b0);
    chk("flush3_b_nzcv", nzcv, 4'b0100);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("flush stage2 nzcv=%b", nzcv);

    // Stream of four flag-setting results.
    begin
      logic [63:0] sres[4];
      logic [3:0]  sz;
      sres[0] = 64'h0; sres[1] = 64'h5; sres[2] = 64'h0; sres[3] = 64'hFFFF_FFFF_FFFF_FFFF;
      sz = 4'b0101; // bit i = expected zero of entry i
      for (int i = 0; i < 6; i++) begin
        if (i < 4) drive(1'b1, sres[i], 1'b0, 1'b0, 1'b1, 1'b0);
        else       drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk($sformatf("stream%0d_pending", i), flags_pending, (i < 4) ? 1'b1 : 1'b0);
        if (i >= 1 && i <= 4) begin
          chk($sformatf("stream%0d_valid", i - 1), out_valid, 1'b1);
          chk($sformatf("stream%0d_zero", i - 1), out_zero, sz[i-1]);
          chk($sformatf("stream%0d_z", i - 1), flag_z, sz[i-1]);
          $display("stream %0d zero=%b nzcv=%b", i - 1, out_zero, nzcv);
        end
      end
      chk("stream_final_nzcv", nzcv, 4'b1000);
      chk("stream_drain_valid", out_valid, 1'b0);
    end

    // Asynchronous reset mid-stream.
    drive(1'b1, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 64'h7, 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_pending", flags_pending, 1'b0);
    chk("midreset_nzcv", nzcv, 4'b0000);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk("midreset_out_valid", out_valid, 1'b0);
    chk("midreset_nzcv_after", nzcv, 4'b0000);
    $display("mid-stream reset nzcv=%b valid=%b", nzcv, out_valid);

    // 32/4 instance: 0x10 then 0, then a one-hot sweep.
    s_in_valid = 1'b1; s_in_result = 32'h0000_0010; s_in_set_flags = 1'b1;
    tick();
    s_in_result = 32'h0;
    tick();
    s_in_valid = 1'b0;
    chk("w32_a_valid", s_out_valid, 1'b1);
    chk("w32_a_zero", s_out_zero, 1'b0);
    chk("w32_a_nzcv", s_nzcv, 4'b0000);
    tick();
    chk("w32_b_valid", s_out_valid, 1'b1);
    chk("w32_b_zero", s_out_zero, 1'b1);
    chk("w32_b_nzcv", s_nzcv, 4'b0100);
    $display("w32 zero=%b nzcv=%b", s_out_zero, s_nzcv);
    s_in_set_flags = 1'b0;
    for (int i = 0; i <= 32; i++) begin
      s_in_valid  = (i < 32);
      s_in_result = (i < 32) ? (32'h1 << i) : 32'h0;
      tick();
      if (i >= 1) begin
        chk($sformatf("w32_sweep%0d_zero", i - 1), s_out_zero, 1'b0);
        chk($sformatf("w32_sweep%0d_nzcv", i - 1), s_nzcv, 4'b0100);
      end
    end
    s_in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zero_flag_pipe.md
Name: zero_flag_pipe

Overview:
- Parametrised, pipelined successor to the flat 64-bit zero detector.
- Takes an ALU result plus carry/overflow and produces a registered zero indication over a two-stage chunked reduction tree.
- Maintains the architectural NZCV flag register, updated only by flag-setting instructions (ADDS/SUBS/ANDS).
- Sits between EX and the branch unit; flags_pending lets hazard logic stall B.cond until an in-flight flag update retires.

Parameters:
- WIDTH, 64, result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits OR-reduced per stage-1 chunk; NCH = WIDTH/CHUNK chunks.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  result presented this cycle.
- in_result  input  WIDTH  ALU result.
- in_carry  input  1  ALU carry-out.
- in_overflow  input  1  ALU signed overflow.
- in_set_flags  input  1  instruction writes NZCV.
- flush  input  1  kill stage-1 entry and any same-cycle input.
- out_valid  output  1  stage-2 result valid.
- out_zero  output  1  in_result was all zeros (qualified by out_valid).
- flag_n, flag_z, flag_c, flag_v  output  1 each  architectural NZCV.
- flags_pending  output  1  stage-1 holds a valid set_flags entry.

Behaviour:
- Reset (async, active-high): all pipeline valids, out_valid, out_zero, NZCV and flags_pending go to 0 immediately and stay 0 while reset is high.
- Stage 1, registered at the clk edge when in_valid && !flush:
  - s1_nz[k] = OR of in_result[k*CHUNK +: CHUNK], for k in 0..NCH-1.
  - Also registers s1_sign = in_result[WIDTH-1], carry, overflow, set_flags.
  - s1_valid <= in_valid && !flush.
- Stage 2:
  - out_valid <= s1_valid && !flush.
  - out_zero <= ~|s1_nz, loaded only when s1_valid && !flush; otherwise it holds its previous value.
- Flag register update, at the same edge as out_valid rises, when s1_valid && s1_set_flags && !flush:
  - flag_n <= s1_sign
  - flag_z <= ~|s1_nz
  - flag_c <= s1_carry
  - flag_v <= s1_overflow
  - NZCV are otherwise held.
- Latency: in_valid at edge T gives out_valid and updated NZCV visible after edge T+1, i.e. 2 cycles. Throughput is 1 per cycle with no bubbles.
- flags_pending = s1_valid && s1_set_flags (combinational from stage-1 regs).
- Flush:
  - Discards the stage-1 entry: no out_valid, no flag update.
  - Also discards the same-cycle input.
  - The entry already in stage 2 (out_valid currently high) is not affected, since its flag update has already committed.
- Back-to-back set_flags entries: each updates NZCV in order; the last one wins.
- A non-set_flags entry between them never disturbs NZCV.
- Reset asserted mid-stream: in-flight entries are lost; there is no partial flag update.
- Width rule: WIDTH % CHUNK != 0 is illegal. An elaboration-time check fails the build.

Test Plan:
- Reset: hold reset 3 cycles with in_valid=1, in_result=0, in_set_flags=1 -> NZCV=0000, out_valid=0, flags_pending=0 throughout.
- Zero detect:
  - in_result=0 with set_flags=1 -> 2 cycles later out_valid=1, out_zero=1, Z=1, N=0.
  - Next, in_result=64'h8000_0000_0000_0000, carry=1, overflow=1 -> out_zero=0, NZCV=1011.
- Single-bit sweep: one-hot in_result=1<<i for i=0..63, set_flags=0 -> out_zero=0 every cycle, NZCV unchanged. This catches chunk boundary errors at bits 7/8, 55/56 etc.
- Flush: issue in_result=0 with set_flags=1, assert flush the next cycle -> no out_valid for that entry, Z keeps its prior value of 0. With flush and in_valid in the same cycle, nothing is captured.
- Stream:
  - Send 4 back-to-back results {0, 5, 0, 0xFFFF_FFFF_FFFF_FFFF}, all with set_flags=1 -> out_zero sequence 1,0,1,0.
  - Final NZCV=1000.
  - flags_pending is high for 4 consecutive cycles.
- Parameter: WIDTH=32, CHUNK=4 -> in_result=32'h0000_0010 gives out_zero=0; in_result=0 gives out_zero=1 with 2-cycle latency.
